// File: rtl/neuron_array_core_pkg.sv
// Shared Q-format widths, defaults and helpers for the neuron array core.
// Everything here is width-generic so the top can override the Q format.
package neuron_array_core_pkg;

  localparam int INT_W_D = 3;
  localparam int FRC_W_D = 12;
  localparam int W_D = 1 + INT_W_D + FRC_W_D;

  localparam int TAU_SHIFT_D = 1;
  localparam int TIME_SHIFT_D = 7;
  localparam int A_CONST_D = 2867;

  localparam logic [W_D-1:0] V_RST_D = 16'hECE1;
  localparam logic [W_D-1:0] W_RST_D = 16'hF600;
  localparam logic [W_D-1:0] V_SPIKE_D = 16'h1000;

  // Half-LSB rounding constant for an arithmetic right shift by sh.
  function automatic int rnd_c(input int sh);
    return (sh > 0) ? (1 << (sh - 1)) : 0;
  endfunction

  function automatic logic signed [31:0] sat_w(
    input logic signed [31:0] x,
    input int w
  );
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/neuron_array_core_pow2.sv
// Piecewise-linear 2^x of a signed Q value: (1 + frac) << floor(x).
// Result is non-negative and clamped to the largest positive W-bit value.
module pow_2_function #(
  parameter int INT_WIDTH = 3,
  parameter int FRC_WIDTH = 12
) (
  input  logic [INT_WIDTH+FRC_WIDTH:0] i_x,
  output logic [INT_WIDTH+FRC_WIDTH:0] o_y
);

  localparam int W = 1 + INT_WIDTH + FRC_WIDTH;
  localparam int PADW = 2 * W - FRC_WIDTH - 1;
  localparam logic [2*W-1:0] MAXV = {{(W + 1){1'b0}}, {(W - 1){1'b1}}};

  logic [INT_WIDTH:0] w_ip;
  logic [INT_WIDTH:0] w_neg;
  logic [2*W-1:0] w_mant;
  logic [2*W-1:0] w_sh;

  assign w_ip = i_x[W-1:FRC_WIDTH];
  assign w_neg = -w_ip;
  assign w_mant = {{PADW{1'b0}}, 1'b1, i_x[FRC_WIDTH-1:0]};
  assign w_sh = w_ip[INT_WIDTH] ? (w_mant >> w_neg)
                                : (w_mant << w_ip);
  assign o_y = (w_sh > MAXV) ? MAXV[W-1:0] : w_sh[W-1:0];

endmodule

// File: rtl/neuron_array_core.sv
// Time-multiplexed two-variable neuron array on a shared 4-stage
// Euler update pipeline with a flop-based per-neuron state file.
module neuron_array_core
  import neuron_array_core_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int INT_WIDTH = INT_W_D,
  parameter int FRC_WIDTH = FRC_W_D,
  parameter int TAU_SHIFT = TAU_SHIFT_D,
  parameter int TIME_SHIFT = TIME_SHIFT_D,
  parameter int A_CONST = A_CONST_D,
  parameter int DEADBAND = 175,
  parameter logic [INT_WIDTH+FRC_WIDTH:0] V_RST = V_RST_D,
  parameter logic [INT_WIDTH+FRC_WIDTH:0] W_RST = W_RST_D,
  parameter logic [INT_WIDTH+FRC_WIDTH:0] V_SPIKE = V_SPIKE_D,
  parameter bit SATURATE = 1'b1,
  localparam int W = 1 + INT_WIDTH + FRC_WIDTH,
  localparam int IW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [IW-1:0] i_idx,
  input  logic [W-1:0]  i_in,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic [W-1:0]  cfg_v,
  input  logic [W-1:0]  cfg_w,
  output logic          out_valid,
  output logic [IW-1:0] out_idx,
  output logic [W-1:0]  v_out,
  output logic [W-1:0]  w_out,
  output logic          spike
);

  localparam int WX = W + 4;
  localparam int SH_W = TAU_SHIFT + TIME_SHIFT;

  typedef logic signed [WX-1:0] wx_t;

  localparam wx_t RND_V = wx_t'(rnd_c(TIME_SHIFT));
  localparam wx_t RND_W = wx_t'(rnd_c(SH_W));
  localparam wx_t A_X = wx_t'(A_CONST);
  localparam wx_t DB = wx_t'(DEADBAND);

  function automatic wx_t sx(input logic [W-1:0] x);
    return wx_t'(signed'(x));
  endfunction

  function automatic logic [W-1:0] fit(input wx_t x);
    logic signed [31:0] s;
    s = SATURATE ? sat_w(32'(x), W) : 32'(x);
    return s[W-1:0];
  endfunction

  logic [W-1:0] r_v [N_NEURONS];
  logic [W-1:0] r_w [N_NEURONS];

  logic r1_vld, r2_vld, r3_vld, r4_vld;
  logic [IW-1:0] r1_idx, r2_idx, r3_idx, r4_idx;
  logic [W-1:0] r1_in;
  logic [W-1:0] r2_v, r2_w, r2_pp, r2_pn;
  logic [W-1:0] r3_v, r3_w, r4_v;
  wx_t r2_in, r2_wp;
  wx_t r3_in, r3_wp, r3_d3, r3_v5;
  wx_t r4_dv, r4_ws;

  logic w_haz, w_xfer;
  logic [W-1:0] w_v1, w_w1, w_nv1, w_pp1, w_pn1;
  logic [W-1:0] w_vn, w_wn;
  logic w_sp;
  wx_t w_wp1, w_d2, w_dv, w_dvz, w_ws, w_vs;

  // A neuron still in stages 1-3 has not written back yet; stage 4
  // commits on the same edge a new transfer is captured.
  always_comb begin
    w_haz = 1'b0;
    if (r1_vld && r1_idx == i_idx) w_haz = 1'b1;
    if (r2_vld && r2_idx == i_idx) w_haz = 1'b1;
    if (r3_vld && r3_idx == i_idx) w_haz = 1'b1;
  end

  assign i_ready = !rst && !cfg_we && !w_haz;
  assign w_xfer = i_valid && i_ready;

  assign w_v1 = r_v[r1_idx];
  assign w_w1 = r_w[r1_idx];
  assign w_nv1 = -w_v1;
  assign w_wp1 = sx(w_v1) + A_X - (sx(w_w1) >>> 1) + RND_W;

  pow_2_function #(
    .INT_WIDTH(INT_WIDTH),
    .FRC_WIDTH(FRC_WIDTH)
  ) u_pp (
    .i_x(w_v1),
    .o_y(w_pp1)
  );

  pow_2_function #(
    .INT_WIDTH(INT_WIDTH),
    .FRC_WIDTH(FRC_WIDTH)
  ) u_pn (
    .i_x(w_nv1),
    .o_y(w_pn1)
  );

  assign w_d2 = wx_t'(r2_pn) - wx_t'(r2_pp);

  assign w_dv = r3_d3 + r3_v5 - sx(r3_w) + r3_in;
  assign w_dvz = (w_dv > -DB && w_dv < DB) ? '0 : w_dv;
  assign w_ws = sx(r3_w) + (r3_wp >>> SH_W);

  assign w_vs = sx(r4_v) + ((r4_dv + RND_V) >>> TIME_SHIFT);
  assign w_vn = fit(w_vs);
  assign w_wn = fit(r4_ws);
  assign w_sp = (signed'(r4_v) < signed'(V_SPIKE)) &&
                (signed'(w_vn) >= signed'(V_SPIKE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld <= 1'b0;
      r2_vld <= 1'b0;
      r3_vld <= 1'b0;
      r4_vld <= 1'b0;
      out_valid <= 1'b0;
      out_idx <= '0;
      v_out <= V_RST;
      w_out <= W_RST;
      spike <= 1'b0;
    end else begin
      r1_vld <= w_xfer;
      r2_vld <= r1_vld;
      r3_vld <= r2_vld;
      r4_vld <= r3_vld;
      out_valid <= r4_vld;
      spike <= r4_vld && w_sp;
      if (r4_vld) begin
        out_idx <= r4_idx;
        v_out <= w_vn;
        w_out <= w_wn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r1_idx <= i_idx;
      r1_in <= i_in;
    end
    r2_idx <= r1_idx;
    r2_in <= sx(r1_in);
    r2_v <= w_v1;
    r2_w <= w_w1;
    r2_pp <= w_pp1;
    r2_pn <= w_pn1;
    r2_wp <= w_wp1;
    r3_idx <= r2_idx;
    r3_in <= r2_in;
    r3_v <= r2_v;
    r3_w <= r2_w;
    r3_wp <= r2_wp;
    r3_d3 <= (w_d2 <<< 1) + w_d2;
    r3_v5 <= (sx(r2_v) <<< 2) + sx(r2_v);
    r4_idx <= r3_idx;
    r4_v <= r3_v;
    r4_dv <= w_dvz;
    r4_ws <= w_ws;
  end

  // Config write is ordered last so it wins over a same-index writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < N_NEURONS; n++) begin
        r_v[n] <= V_RST;
        r_w[n] <= W_RST;
      end
    end else begin
      if (r4_vld) begin
        r_v[r4_idx] <= w_vn;
        r_w[r4_idx] <= w_wn;
      end
      if (cfg_we) begin
        r_v[cfg_idx] <= cfg_v;
        r_w[cfg_idx] <= cfg_w;
      end
    end
  end

endmodule
